// File: rtl/aes_encrypt.sv
// Iterative AES encryptor: the key schedule is expanded one word per clock, then
// one cipher round is applied per clock. Supports AES-128, AES-192 and AES-256.
module aes_encrypt #(
    parameter int KEY_BITS = 128,
    parameter int NR       = 10,
    parameter int NK       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] key,
    output logic [127:0]        out_data,
    output logic                busy,
    output logic                done
);

    localparam bit LEGAL = (KEY_BITS == 128 && NR == 10 && NK == 4) ||
                           (KEY_BITS == 192 && NR == 12 && NK == 6) ||
                           (KEY_BITS == 256 && NR == 14 && NK == 8);

    generate
        if (!LEGAL) begin : g_illegal_params
            $error("aes_encrypt: unsupported (KEY_BITS, NR, NK) combination");
        end
    endgenerate

    localparam int         NW     = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [3:0] NR_W   = 4'(NR);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = SBOX[s[127-8*k -: 8]];
        return o;
    endfunction

    // Byte k of the block sits in column k/4, row k%4; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = x;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} state_t;

    state_t       st;
    logic [31:0]  w [0:NW-1];
    logic [127:0] blk;
    logic [5:0]   idx;
    logic [2:0]   kmod;
    logic [3:0]   rnd;
    logic [7:0]   rcon;

    logic [31:0]  prev_w, temp;
    logic [5:0]   rk_base;
    logic [127:0] rk, shifted, round_out, final_out;

    always_comb begin
        prev_w = w[idx - 6'd1];
        temp   = prev_w;
        if (kmod == 3'd0)
            temp = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon, 24'h0};
        else if (NK == 8 && kmod == 3'd4)
            temp = sub_word(prev_w);
    end

    // rnd is 0 during INIT, so the same selector yields the whitening key there.
    always_comb begin
        rk_base   = {rnd, 2'b00};
        rk        = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
        shifted   = shift_rows(sub_bytes(blk));
        round_out = mix_columns(shifted) ^ rk;
        final_out = shifted ^ rk;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            blk      <= '0;
            idx      <= '0;
            kmod     <= '0;
            rnd      <= '0;
            rcon     <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        blk <= in_data;
                        for (int j = 0; j < NK; j++)
                            w[j] <= key[KEY_BITS-1-32*j -: 32];
                        idx  <= NK_W;
                        kmod <= 3'd0;
                        rcon <= 8'h01;
                        rnd  <= 4'd0;
                        busy <= 1'b1;
                        st   <= KEXP;
                    end
                end
                KEXP: begin
                    w[idx] <= w[idx - NK_W] ^ temp;
                    idx    <= idx + 6'd1;
                    kmod   <= (kmod == NK_M1) ? 3'd0 : kmod + 3'd1;
                    if (kmod == 3'd0)
                        rcon <= xt(rcon);
                    if (idx == LAST_W)
                        st <= INIT;
                end
                INIT: begin
                    blk <= blk ^ rk;
                    rnd <= 4'd1;
                    st  <= ROUND;
                end
                ROUND: begin
                    if (rnd == NR_W) begin
                        out_data <= final_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        rnd      <= 4'd0;
                        st       <= IDLE;
                    end else begin
                        blk <= round_out;
                        rnd <= rnd + 4'd1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt.sv
// Directed FIPS-197 vectors plus control-path scenarios for the iterative AES core.
module tb_aes_encrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start128, start192, start256;
    logic [127:0] in_data;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [127:0] out128, out192, out256;
    logic         busy128, busy192, busy256;
    logic         done128, done192, done256;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2_OUT = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3_OUT = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encrypt #(.KEY_BITS(128), .NR(10), .NK(4)) dut128 (
        .clk(clk), .reset(reset), .start(start128), .in_data(in_data), .key(key128),
        .out_data(out128), .busy(busy128), .done(done128));
    aes_encrypt #(.KEY_BITS(192), .NR(12), .NK(6)) dut192 (
        .clk(clk), .reset(reset), .start(start192), .in_data(in_data), .key(key192),
        .out_data(out192), .busy(busy192), .done(done192));
    aes_encrypt #(.KEY_BITS(256), .NR(14), .NK(8)) dut256 (
        .clk(clk), .reset(reset), .start(start256), .in_data(in_data), .key(key256),
        .out_data(out256), .busy(busy256), .done(done256));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic dn(input int s);
        case (s)
            0:       return done128;
            1:       return done192;
            default: return done256;
        endcase
    endfunction

    // Returns #1 after the accepting edge; k is left-aligned for all key widths.
    task automatic launch(input int s, input logic [127:0] din, input logic [255:0] k, input bit hold);
        @(negedge clk);
        in_data = din;
        key128  = k[255:128];
        key192  = k[255:64];
        key256  = k;
        case (s)
            0:       start128 = 1'b1;
            1:       start192 = 1'b1;
            default: start256 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        if (!hold) begin
            start128 = 1'b0;
            start192 = 1'b0;
            start256 = 1'b0;
        end
    endtask

    task automatic wait_done(input int s, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dn(s) && n < 200);
    endtask

    initial begin
        int  n;
        int  pulses;
        logic hold_ok;

        reset = 1'b1; start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
        in_data = '0; key128 = '0; key192 = '0; key256 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out128, 128'h0);
        chk("reset_busy_done", {126'h0, busy128, done128}, 128'h0);
        @(negedge clk);
        reset = 1'b0;

        // FIPS-197 App. B
        launch(0, B_IN, {B_KEY, 128'h0}, 1'b0);
        chk("b_busy", {127'h0, busy128}, 128'h1);
        wait_done(0, n);
        chk("b_latency", 128'(n), 128'd51);
        chk("b_out", out128, B_OUT);
        chk("b_busy_clear", {127'h0, busy128}, 128'h0);
        @(posedge clk);
        #1;
        chk("b_done_width", {127'h0, done128}, 128'h0);
        chk("b_out_hold", out128, B_OUT);

        // App. C.1
        launch(0, C_IN, K256, 1'b0);
        wait_done(0, n);
        chk("c1_latency", 128'(n), 128'd51);
        chk("c1_out", out128, C1_OUT);

        // start with different data while busy must be ignored
        launch(0, C_IN, K256, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        in_data = B_IN; key128 = B_KEY; start128 = 1'b1;
        @(posedge clk);
        #1;
        start128 = 1'b0;
        wait_done(0, n);
        chk("ign_latency", 128'(n + 11), 128'd51);
        chk("ign_out", out128, C1_OUT);
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done128) pulses++;
        end
        chk("ign_extra_done", 128'(pulses), 128'd0);

        // reset 20 cycles into an operation
        launch(0, B_IN, {B_KEY, 128'h0}, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out", out128, 128'h0);
        chk("abort_busy_done", {126'h0, busy128, done128}, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done128) pulses++;
        end
        chk("abort_no_done", 128'(pulses), 128'd0);
        launch(0, C_IN, K256, 1'b0);
        wait_done(0, n);
        chk("abort_restart_latency", 128'(n), 128'd51);
        chk("abort_restart_out", out128, C1_OUT);

        // back-to-back: start held high across the done cycle
        launch(0, B_IN, {B_KEY, 128'h0}, 1'b1);
        wait_done(0, n);
        chk("b2b_first_latency", 128'(n), 128'd51);
        chk("b2b_first_out", out128, B_OUT);
        in_data = C_IN;
        key128  = K256[255:128];
        @(posedge clk);
        #1;
        start128 = 1'b0;
        chk("b2b_accepted", {126'h0, busy128, done128}, 128'h2);
        n = 0;
        hold_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!done128 && out128 !== B_OUT) hold_ok = 1'b0;
        end while (!done128 && n < 200);
        chk("b2b_hold", {127'h0, hold_ok}, 128'h1);
        chk("b2b_second_latency", 128'(n), 128'd51);
        chk("b2b_second_out", out128, C1_OUT);

        // App. C.2 / C.3
        launch(1, C_IN, K256, 1'b0);
        wait_done(1, n);
        chk("c2_latency", 128'(n), 128'd59);
        chk("c2_out", out192, C2_OUT);

        launch(2, C_IN, K256, 1'b0);
        wait_done(2, n);
        chk("c3_latency", 128'(n), 128'd67);
        chk("c3_out", out256, C3_OUT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- KEY_BITS, 128, cipher key width
- NR, 10, number of rounds
- NK, 4, key length in 32-bit words
REQ-002 Only (128,10,4), (192,12,6) and (256,14,8) SHALL be legal parameter sets; any other set SHALL be a static elaboration error.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock, rising edge
- reset, input, 1, synchronous active-high reset
- start, input, 1, request to encrypt in_data with key
- in_data, input, 128, plaintext block (FIPS-197 byte order, byte 0 = bits 127:120)
- key, input, KEY_BITS, cipher key (same byte order)
- out_data, output, 128, ciphertext, registered
- busy, output, 1, operation in progress
- done, output, 1, one-cycle pulse, out_data newly valid
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 The block SHALL implement FIPS-197 AES encryption (SubBytes, ShiftRows, MixColumns, AddRoundKey; MixColumns omitted in round NR).
REQ-006 The FSM SHALL have states IDLE, KEXP, INIT and ROUND.
REQ-007 IDLE with start=1: on that edge, capture in_data, load key into words w[0..NK-1], set i=NK, busy=1, go to KEXP.
REQ-008 Start SHALL be ignored while busy=1; in_data and key SHALL be ignored except on the accepting edge.
REQ-009 KEXP: each edge computes one word w[i] per the FIPS-197 expansion, i.e. w[i]=w[i-NK]^temp, where:
- temp=SubWord(RotWord(w[i-1]))^Rcon[i/NK] when i mod NK=0;
- temp=SubWord(w[i-1]) when NK=8 and i mod NK=4;
- otherwise temp=w[i-1].
REQ-010 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 in the MSB; KEXP SHALL end after w[4*NR+3] and go to INIT.
REQ-011 INIT, one edge: state = plaintext XOR w[0..3]; round=1; go to ROUND.
REQ-012 ROUND: each edge applies round r with round key w[4r..4r+3]. After round NR, on the same edge:
- out_data <= result;
- done <= 1;
- busy <= 0;
- go to IDLE.
REQ-013 Latency SHALL be fixed: done is high (4*(NR+1)-NK)+1+NR edges after the accepting edge. This is 51 for AES-128, 59 for AES-192 and 67 for AES-256.
REQ-014 done SHALL be high for exactly one cycle. out_data SHALL hold until the next completion; intermediate state SHALL never appear on out_data.
REQ-015 start in the cycle done is high SHALL be accepted (back-to-back operation).
REQ-016 The S-box SHALL be the FIPS-197 S-box, implemented either as a table or as GF(2^8) inverse plus affine transform; either form is permitted. xtime SHALL reduce by 0x1b.

Reset
REQ-017 With reset=1 at an edge: state IDLE, busy=0, done=0, out_data=0, counters 0.
REQ-018 Reset SHALL override start and abort any operation in progress; no done pulse SHALL follow an aborted operation.

Verification
REQ-019 AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32, done 51 edges after the accepting edge.
REQ-020 AES-128 (App. C.1): key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-021 AES-192 (App. C.2): key 000102...1617, same in -> dda97ca4864cdfe06eaf70a0ec0d7191 after 59 edges. AES-256 (App. C.3): key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089 after 67 edges.
REQ-022 Start pulsed while busy with different data -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-023 Reset asserted 20 cycles into an operation -> out_data=0, busy=0, no done. A fresh start afterwards -> correct result with nominal latency.
REQ-024 Back-to-back: start held high across the done cycle -> second operation accepted on that edge; second done follows after nominal latency; out_data holds the first result until then.
